cam_lookup_ctrl: RTL and testbench
==================================

CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, CAM data width.
REQ-002 SHALL have parameter TAG_SZ, default 8, CAM tag width.
REQ-003 SHALL have parameter WORDS, default 8, number of CAM entries (power of 2); AW = $clog2(WORDS).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports req_valid in 1, req_tag in TAG_SZ, req_ready out 1  lookup request handshake.
REQ-007 SHALL have ports rsp_valid out 1, rsp_data out BITS, rsp_hit out 1, rsp_ready in 1  response handshake.
REQ-008 SHALL have ports cam_check_tag out TAG_SZ, cam_read out 1, cam_data in BITS, cam_found_it in 1  CAM search port.
REQ-009 SHALL have ports cam_write_ out 1 (active-low), cam_w_addr out AW, cam_wdata out BITS, cam_new_tag out TAG_SZ, cam_new_valid out 1  CAM write port.
REQ-010 SHALL have ports fill_req out 1, fill_tag out TAG_SZ, fill_ack in 1, fill_data in BITS  miss backing-store port.
REQ-011 SHALL have port flush in 1  level request to invalidate all CAM entries.

Function
REQ-012 SHALL implement FSM states IDLE, LOOKUP, CHECK, FILL, WRITE, RESP, FLUSH.
REQ-013 SHALL assert req_ready only in IDLE with flush low; request accepted on edge where req_valid & req_ready; req_tag latched; next state LOOKUP.
REQ-014 SHALL, in IDLE with flush high, enter FLUSH; flush has priority over a simultaneous req_valid.
REQ-015 SHALL, in LOOKUP, drive cam_read=1 and cam_check_tag=latched tag for exactly one cycle, then enter CHECK.
REQ-016 SHALL, in CHECK, sample cam_found_it/cam_data (CAM result valid one cycle after cam_read); hit -> RESP with rsp_hit=1, rsp_data=cam_data; miss -> FILL.
REQ-017 SHALL, in FILL, hold fill_req=1 and fill_tag=latched tag until fill_ack=1; capture fill_data on that edge; next state WRITE; fill_ack outside FILL ignored.
REQ-018 SHALL, in WRITE, drive cam_write_=0 for exactly one cycle with cam_w_addr=victim pointer, cam_new_tag=latched tag, cam_wdata=fill data, cam_new_valid=1; then RESP with rsp_hit=0, rsp_data=fill data.
REQ-019 SHALL increment the AW-bit victim pointer by 1 after each WRITE, wrapping WORDS-1 -> 0 (round-robin replacement).
REQ-020 SHALL, in RESP, hold rsp_valid=1 and rsp_data/rsp_hit stable until rsp_ready=1; on that edge return to IDLE.
REQ-021 SHALL, in FLUSH, issue WORDS consecutive write cycles, cam_write_=0, cam_new_valid=0, cam_new_tag=0, cam_wdata=0, cam_w_addr=0..WORDS-1; then reset victim pointer to 0 and return to IDLE.
REQ-022 SHALL sample flush only in IDLE; flush asserted mid-transaction is honoured after return to IDLE if still high.
REQ-023 SHALL drive cam_write_=1, cam_read=0, fill_req=0, rsp_valid=0 in every state not granting them above.
REQ-024 SHALL give hit latency: acceptance edge E0, rsp_valid high after edge E2; miss latency E2 + fill wait + 1 write cycle + 1.
REQ-025 SHALL never issue cam_read and cam_write_=0 in the same cycle.

Reset
REQ-026 SHALL, on rst_=0, immediately force state IDLE, victim pointer 0, latched tag/data 0, rsp_valid 0, rsp_hit 0, rsp_data 0, cam_read 0, cam_write_ 1, cam_new_valid 0, fill_req 0, all address/tag/data outputs 0.
REQ-027 SHALL abandon any in-flight transaction on reset with no CAM write and no response; req_ready=1 in first cycle after rst_ release (flush low).

Verification
REQ-028 SHALL verify reset: rst_=0 mid-FILL -> fill_req drops asynchronously, cam_write_=1, rsp_valid=0; after release req_ready=1.
REQ-029 SHALL verify hit: CAM holds tag 0x05 -> 0x11; request 0x05 -> rsp_hit=1, rsp_data=0x11 after E2, no fill_req, cam_write_ stays 1.
REQ-030 SHALL verify miss: tag 0x07 absent, fill_ack after 3 cycles with fill_data=0x22 -> one write addr 0, tag 0x07, wdata 0x22, new_valid 1; rsp_hit=0, rsp_data=0x22; victim pointer 1.
REQ-031 SHALL verify wrap: 9 consecutive misses (tags 0x10..0x18) -> write addresses 0,1,...,7,0.
REQ-032 SHALL verify flush: flush=1 with req_valid=1 in IDLE -> 8 write cycles addr 0..7, new_valid 0, req_ready 0 throughout, then request accepted, victim pointer 0.
REQ-033 SHALL verify backpressure: rsp_ready low 4 cycles -> rsp_valid, rsp_data, rsp_hit stable; no new request accepted until rsp_ready edge.

Source files
------------

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: CAM lookup controller with miss fill, round-robin replacement and flush
// Ports:
//   clk, rst_                      clock, async active-low reset
//   req_valid/req_tag/req_ready    lookup request handshake
//   rsp_valid/rsp_data/rsp_hit/rsp_ready  response handshake
//   cam_check_tag/cam_read/cam_data/cam_found_it  CAM search port (result one cycle after cam_read)
//   cam_write_/cam_w_addr/cam_wdata/cam_new_tag/cam_new_valid  CAM write port (write strobe active-low)
//   fill_req/fill_tag/fill_ack/fill_data  backing store for misses
//   flush                          level request to invalidate every CAM entry
module cam_lookup_ctrl #(
    parameter int BITS   = 8,
    parameter int TAG_SZ = 8,
    parameter int WORDS  = 8,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    input  logic [TAG_SZ-1:0] req_tag,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [BITS-1:0]   rsp_data,
    output logic              rsp_hit,
    input  logic              rsp_ready,
    output logic [TAG_SZ-1:0] cam_check_tag,
    output logic              cam_read,
    input  logic [BITS-1:0]   cam_data,
    input  logic              cam_found_it,
    output logic              cam_write_,
    output logic [AW-1:0]     cam_w_addr,
    output logic [BITS-1:0]   cam_wdata,
    output logic [TAG_SZ-1:0] cam_new_tag,
    output logic              cam_new_valid,
    output logic              fill_req,
    output logic [TAG_SZ-1:0] fill_tag,
    input  logic              fill_ack,
    input  logic [BITS-1:0]   fill_data,
    input  logic              flush
);
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, FILL, WRITE, RESP, FLUSH} state_t;
    state_t            state_q, state_d;
    logic [TAG_SZ-1:0] tag_q, tag_d;
    logic [BITS-1:0]   data_q, data_d;
    logic              hit_q, hit_d;
    logic [AW-1:0]     vptr_q, vptr_d;
    logic [AW-1:0]     fcnt_q, fcnt_d;
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            tag_q   <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
            vptr_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
            vptr_q  <= vptr_d;
            fcnt_q  <= fcnt_d;
        end
    end
    // data_q holds either the CAM hit data or the fill data, so it feeds both
    // the write port and the response without a second register.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        data_d        = data_q;
        hit_d         = hit_q;
        vptr_d        = vptr_q;
        fcnt_d        = fcnt_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = data_q;
        rsp_hit       = hit_q;
        cam_read      = 1'b0;
        cam_check_tag = '0;
        cam_write_    = 1'b1;
        cam_w_addr    = '0;
        cam_wdata     = '0;
        cam_new_tag   = '0;
        cam_new_valid = 1'b0;
        fill_req      = 1'b0;
        fill_tag      = '0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                fcnt_d    = '0;
                if (flush) begin
                    state_d = FLUSH;
                end else if (req_valid) begin
                    tag_d   = req_tag;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                cam_read      = 1'b1;
                cam_check_tag = tag_q;
                state_d       = CHECK;
            end
            CHECK: begin
                hit_d   = cam_found_it;
                data_d  = cam_found_it ? cam_data : data_q;
                state_d = cam_found_it ? RESP : FILL;
            end
            FILL: begin
                fill_req = 1'b1;
                fill_tag = tag_q;
                if (fill_ack) begin
                    data_d  = fill_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cam_write_    = 1'b0;
                cam_w_addr    = vptr_q;
                cam_new_tag   = tag_q;
                cam_wdata     = data_q;
                cam_new_valid = 1'b1;
                vptr_d        = vptr_q + 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = rsp_ready ? IDLE : RESP;
            end
            FLUSH: begin
                cam_write_ = 1'b0;
                cam_w_addr = fcnt_q;
                fcnt_d     = fcnt_q + 1'b1;
                if (fcnt_q == AW'(WORDS - 1)) begin
                    vptr_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb_cam_lookup_ctrl: directed bench with a CAM environment and a cache-level reference model
module tb_cam_lookup_ctrl;
    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_tag = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_hit;
    logic       rsp_ready = 1'b0;
    logic [7:0] cam_check_tag;
    logic       cam_read;
    logic [7:0] cam_data = '0;
    logic       cam_found_it = 1'b0;
    logic       cam_write_;
    logic [2:0] cam_w_addr;
    logic [7:0] cam_wdata;
    logic [7:0] cam_new_tag;
    logic       cam_new_valid;
    logic       fill_req;
    logic [7:0] fill_tag;
    logic       fill_ack = 1'b0;
    logic [7:0] fill_data = '0;
    logic       flush = 1'b0;

    cam_lookup_ctrl dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_ready(rsp_ready),
        .cam_check_tag(cam_check_tag), .cam_read(cam_read), .cam_data(cam_data), .cam_found_it(cam_found_it),
        .cam_write_(cam_write_), .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata),
        .cam_new_tag(cam_new_tag), .cam_new_valid(cam_new_valid),
        .fill_req(fill_req), .fill_tag(fill_tag), .fill_ack(fill_ack), .fill_data(fill_data),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // CAM environment: stores what the DUT writes, answers searches one cycle later
    logic       pre_go = 1'b0;
    logic [7:0] e_tag [8];
    logic [7:0] e_data[8];
    logic       e_valid[8];

    function automatic logic e_hit(input logic [7:0] t);
        for (int i = 0; i < 8; i++) if (e_valid[i] === 1'b1 && e_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] e_get(input logic [7:0] t);
        for (int i = 0; i < 8; i++) if (e_valid[i] === 1'b1 && e_tag[i] == t) return e_data[i];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (pre_go) begin
            for (int i = 0; i < 8; i++) e_valid[i] <= (i == 0);
            e_tag[0]  <= 8'h05;
            e_data[0] <= 8'h11;
        end else if (!cam_write_) begin
            e_tag[cam_w_addr]   <= cam_new_tag;
            e_data[cam_w_addr]  <= cam_wdata;
            e_valid[cam_w_addr] <= cam_new_valid;
        end
        cam_found_it <= cam_read && e_hit(cam_check_tag);
        cam_data     <= e_get(cam_check_tag);
    end

    // Reference model: an 8-entry cache with round-robin insertion on miss
    logic [7:0] m_tag [8];
    logic [7:0] m_data[8];
    logic       m_valid[8];
    int         m_vptr = 0;
    int         m_fidx = 0;
    int         n_wr = 0;
    int         n_fl = 0;
    logic [2:0] wr_log[64];
    logic [7:0] cur_tag = '0;
    logic [7:0] cur_fd = '0;
    logic       exp_hit = 1'b0;
    logic [7:0] exp_data = '0;

    always @(negedge clk) begin
        if (!rst_) begin
            m_vptr <= 0;
            m_fidx <= 0;
        end else if (pre_go) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= (i == 0);
            m_tag[0]  <= 8'h05;
            m_data[0] <= 8'h11;
        end else begin
            chk("read_write_overlap", 32'(cam_read & ~cam_write_), 0);
            if (cam_read) chk("check_tag", 32'(cam_check_tag), 32'(cur_tag));
            if (fill_req) begin
                chk("fill_on_hit", 32'(exp_hit), 0);
                chk("fill_tag", 32'(fill_tag), 32'(cur_tag));
            end
            if (rsp_valid) begin
                chk("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                chk("rsp_data", 32'(rsp_data), 32'(exp_data));
                chk("ready_in_rsp", 32'(req_ready), 0);
            end
            if (!cam_write_ && cam_new_valid) begin
                chk("wr_addr", 32'(cam_w_addr), m_vptr);
                chk("wr_tag", 32'(cam_new_tag), 32'(cur_tag));
                chk("wr_data", 32'(cam_wdata), 32'(cur_fd));
                chk("write_on_hit", 32'(exp_hit), 0);
                m_tag[m_vptr]   <= cur_tag;
                m_data[m_vptr]  <= cur_fd;
                m_valid[m_vptr] <= 1'b1;
                m_vptr          <= (m_vptr + 1) % 8;
                wr_log[n_wr % 64] <= cam_w_addr;
                n_wr            <= n_wr + 1;
            end
            if (!cam_write_ && !cam_new_valid) begin
                chk("flush_addr", 32'(cam_w_addr), m_fidx);
                chk("flush_tag", 32'(cam_new_tag), 0);
                chk("flush_data", 32'(cam_wdata), 0);
                chk("ready_in_flush", 32'(req_ready), 0);
                m_valid[m_fidx] <= 1'b0;
                m_fidx          <= (m_fidx + 1) % 8;
                if (m_fidx == 7) m_vptr <= 0;
                n_fl            <= n_fl + 1;
            end
        end
    end

    logic       g_hit;
    logic [7:0] g_data;
    int         lat, rcyc, nwr;

    // At a negedge: predict the outcome from the model, then raise req_valid
    task automatic arm(input logic [7:0] tag, input logic [7:0] fd);
        int k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) chk("ready_timeout", 1, 0);
        cur_tag = tag;
        cur_fd  = fd;
        exp_hit = 1'b0;
        exp_data = fd;
        for (int i = 0; i < 8; i++)
            if (m_valid[i] === 1'b1 && m_tag[i] == tag) begin
                exp_hit  = 1'b1;
                exp_data = m_data[i];
            end
        req_valid = 1'b1;
        req_tag   = tag;
    endtask

    task automatic txn(input logic [7:0] tag, input logic [7:0] fd, input int flat, input int bp);
        int w0, fcnt, t, first;
        bit done;
        @(negedge clk);
        arm(tag, fd);
        w0 = n_wr;
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0; fcnt = 0; rcyc = 0; first = 0; done = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
            fill_ack = 1'b0;
            if (fill_req) begin
                fcnt++;
                if (fcnt == flat) begin
                    fill_ack  = 1'b1;
                    fill_data = fd;
                end
            end
            if (rsp_valid) begin
                if (rcyc == 0) begin
                    first  = t;
                    g_hit  = rsp_hit;
                    g_data = rsp_data;
                end
                rcyc++;
                if (rcyc > bp) begin
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    #1 rsp_ready = 1'b0;
                    done = 1;
                end
            end
        end
        fill_ack = 1'b0;
        if (!done) chk("rsp_timeout", 1, 0);
        lat = first;
        nwr = n_wr - w0;
    endtask

    initial begin
        int f0, w0, k;
        #12;
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_strobes", 32'({rsp_valid, rsp_hit, cam_read, cam_write_, cam_new_valid, fill_req}), 32'b000100);
        chk("reset_buses", 32'({rsp_data, cam_w_addr, cam_wdata, cam_new_tag}), 0);
        chk("reset_tags", 32'({cam_check_tag, fill_tag}), 0);
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(req_ready), 1);
        pre_go = 1'b1;
        @(posedge clk);
        #1 pre_go = 1'b0;

        // hit on preloaded tag 0x05 -> 0x11
        txn(8'h05, 8'h00, 1, 0);
        chk("hit_flag", 32'(g_hit), 1);
        chk("hit_data", 32'(g_data), 32'h11);
        chk("hit_latency", lat, 3);
        chk("hit_writes", nwr, 0);

        // miss on 0x07, fill acknowledged on the third fill cycle
        txn(8'h07, 8'h22, 3, 0);
        chk("miss_flag", 32'(g_hit), 0);
        chk("miss_data", 32'(g_data), 32'h22);
        chk("miss_latency", lat, 7);
        chk("miss_writes", nwr, 1);
        chk("miss_addr", 32'(wr_log[(n_wr - 1) % 64]), 0);

        // flush wins over a simultaneous request, then the request is served
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_tag = 8'h40;
        f0 = n_fl;
        @(posedge clk);
        #1 flush = 1'b0;
        txn(8'h40, 8'h44, 2, 0);
        chk("flush_cycles", n_fl - f0, 8);
        chk("post_flush_miss", 32'(g_hit), 0);
        chk("post_flush_addr", 32'(wr_log[(n_wr - 1) % 64]), 0);

        // reset while waiting on the fill
        @(negedge clk);
        arm(8'h30, 8'h33);
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (!fill_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("fill_seen", 32'(fill_req), 1);
        w0 = n_wr;
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1 chk("rst_fill_req", 32'(fill_req), 0);
        chk("rst_write", 32'(cam_write_), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(posedge clk);
        #3 rst_ = 1'b1;
        #1 chk("rst_release_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1 chk("rst_ready_cycle", 32'(req_ready), 1);
        chk("rst_no_write", n_wr - w0, 0);

        // nine misses walk the victim pointer 0..7 and wrap to 0
        for (int i = 0; i < 9; i++) begin
            txn(8'h10 + 8'(i), 8'h80 + 8'(i), 1, 0);
            chk("wrap_addr", 32'(wr_log[(n_wr - 1) % 64]), i % 8);
            chk("wrap_data", 32'(g_data), 32'h80 + i);
            if (i == 0) chk("fill1_latency", lat, 5);
        end

        // backpressure on a hit of 0x18 (now in entry 0 with 0x88)
        txn(8'h18, 8'h00, 1, 4);
        chk("bp_hit", 32'(g_hit), 1);
        chk("bp_data", 32'(g_data), 32'h88);
        chk("bp_rsp_cycles", rcyc, 5);
        chk("bp_writes", nwr, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end
endmodule
